// File: rtl/up_counter.sv
// Enable-gated binary up-counter with configurable terminal value, combinational carry-out and sticky wrap flag.
// Define UP_COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping to zero.
module up_counter #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_reg;
  logic             wrapped_next;
  logic             at_max;

  assign at_max = (count_reg == MAX_COUNT);

  // An X/Z enb falls through to the hold branch, so state is never corrupted.
  always_comb begin
    count_next   = count_reg;
    wrapped_next = wrapped_reg;
    if (enb) begin
      if (count_reg < MAX_COUNT) begin
        count_next = count_reg + WIDTH'(1);
      end else if (at_max) begin
`ifdef UP_COUNTER_SATURATE_EN
        count_next = MAX_COUNT;
`else
        count_next = '0;
`endif
        wrapped_next = 1'b1;
      end else begin
        // Out-of-range value (never reached from reset): recover to zero.
        count_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  // Unregistered so a downstream stage can use tc directly as its enb.
  assign tc      = enb && at_max;
  assign count   = count_reg;
  assign wrapped = wrapped_reg;

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: full-range (MAX_COUNT=15) and reduced (MAX_COUNT=9) instances
// driven in lockstep, with a reference model pushing expectations into a scoreboard queue.
module tb_up_counter;

`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       enb;
  logic [3:0] count;
  logic       tc;
  logic       wrapped;
  logic [3:0] count9;
  logic       tc9;
  logic       wrapped9;

  up_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .count(count), .tc(tc), .wrapped(wrapped)
  );

  up_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) dut9 (
    .clk(clk), .rst(rst), .enb(enb), .count(count9), .tc(tc9), .wrapped(wrapped9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] c;
    logic       w;
    logic [3:0] c9;
    logic       w9;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_item;

  logic [3:0] m_c, m_c9;
  logic       m_w, m_w9;
  logic       exp_tc, exp_tc9;
  logic       tc_known;
  int         errors = 0;
  int         checks = 0;

  function automatic void model_step(inout logic [3:0] c, inout logic w, input logic [3:0] max);
    if (c == max) begin
      w = 1'b1;
      c = SAT ? max : 4'd0;
    end else if (c < max) begin
      c = c + 4'd1;
    end else begin
      c = 4'd0;
    end
  endfunction

  // Drives one cycle of stimulus, records the expected tc for the current cycle and
  // pushes the expected post-edge state to the scoreboard.
  task automatic drive(input logic r, input logic e);
    exp_t it;
    rst      = r;
    enb      = e;
    tc_known = !$isunknown(enb);
    exp_tc   = (enb === 1'b1) && (m_c == 4'd15);
    exp_tc9  = (enb === 1'b1) && (m_c9 == 4'd9);
    if (r) begin
      m_c = 4'd0; m_w = 1'b0; m_c9 = 4'd0; m_w9 = 1'b0;
    end else if (enb === 1'b1) begin
      model_step(m_c, m_w, 4'd15);
      model_step(m_c9, m_w9, 4'd9);
    end
    it.c = m_c; it.w = m_w; it.c9 = m_c9; it.w9 = m_w9;
    sb_q.push_back(it);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enb = 1'b1;
    @(posedge clk); #1;
    m_c = 4'd0; m_w = 1'b0; m_c9 = 4'd0; m_w9 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 2, 1'b1);
      #1;
      checks++;
      if ({tc, tc9} !== {exp_tc, exp_tc9}) begin
        errors++;
        $display("FAIL reset_tc cyc=%0d got tc=%b tc9=%b want %b %b", i, tc, tc9, exp_tc, exp_tc9);
      end
      @(posedge clk); #1;
      e_item = sb_q.pop_front();
      checks++;
      if ({count, wrapped, count9, wrapped9} !== {e_item.c, e_item.w, e_item.c9, e_item.w9}) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got c=%0d w=%b c9=%0d w9=%b want c=%0d w=%b c9=%0d w9=%b",
                 i, count, wrapped, count9, wrapped9, e_item.c, e_item.w, e_item.c9, e_item.w9);
      end
    end
  endtask

  task automatic test_enable_gating();
    // reset, 5 enabled, 3 held, 1 enabled: expect 5 held then 6
    logic [9:0] r_pat = 10'b0000000001;
    logic [9:0] e_pat = 10'b1000111110;
    for (int i = 0; i < 10; i++) begin
      drive(r_pat[i], e_pat[i]);
      #1;
      checks++;
      if ({tc, tc9} !== {exp_tc, exp_tc9}) begin
        errors++;
        $display("FAIL gate_tc cyc=%0d got tc=%b tc9=%b want %b %b", i, tc, tc9, exp_tc, exp_tc9);
      end
      @(posedge clk); #1;
      e_item = sb_q.pop_front();
      checks++;
      if ({count, wrapped, count9, wrapped9} !== {e_item.c, e_item.w, e_item.c9, e_item.w9}) begin
        errors++;
        $display("FAIL gate_state cyc=%0d got c=%0d w=%b c9=%0d w9=%b want c=%0d w=%b c9=%0d w9=%b",
                 i, count, wrapped, count9, wrapped9, e_item.c, e_item.w, e_item.c9, e_item.w9);
      end
    end
  endtask

  task automatic test_wrap();
    // from reset, 20 enabled edges: crosses 9 and 15 terminal values
    for (int i = 0; i < 21; i++) begin
      drive(i == 0, 1'b1);
      #1;
      checks++;
      if ({tc, tc9} !== {exp_tc, exp_tc9}) begin
        errors++;
        $display("FAIL wrap_tc cyc=%0d got tc=%b tc9=%b want %b %b (c=%0d c9=%0d)",
                 i, tc, tc9, exp_tc, exp_tc9, count, count9);
      end
      @(posedge clk); #1;
      e_item = sb_q.pop_front();
      checks++;
      if ({count, wrapped, count9, wrapped9} !== {e_item.c, e_item.w, e_item.c9, e_item.w9}) begin
        errors++;
        $display("FAIL wrap_state cyc=%0d got c=%0d w=%b c9=%0d w9=%b want c=%0d w=%b c9=%0d w9=%b",
                 i, count, wrapped, count9, wrapped9, e_item.c, e_item.w, e_item.c9, e_item.w9);
      end
    end
  endtask

  task automatic test_reset_mid();
    // reset, count to 7, reset with enb; count to 15, reset with enb at terminal value
    for (int i = 0; i < 26; i++) begin
      drive((i == 0) || (i == 8) || (i == 24), i != 0);
      #1;
      checks++;
      if ({tc, tc9} !== {exp_tc, exp_tc9}) begin
        errors++;
        $display("FAIL rstmid_tc cyc=%0d got tc=%b tc9=%b want %b %b", i, tc, tc9, exp_tc, exp_tc9);
      end
      @(posedge clk); #1;
      e_item = sb_q.pop_front();
      checks++;
      if ({count, wrapped, count9, wrapped9} !== {e_item.c, e_item.w, e_item.c9, e_item.w9}) begin
        errors++;
        $display("FAIL rstmid_state cyc=%0d got c=%0d w=%b c9=%0d w9=%b want c=%0d w=%b c9=%0d w9=%b",
                 i, count, wrapped, count9, wrapped9, e_item.c, e_item.w, e_item.c9, e_item.w9);
      end
    end
  endtask

  task automatic test_x_enb();
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, (i > 0 && i < 4) ? 1'b1 : 1'bx);
      #1;
      if (tc_known) begin
        checks++;
        if ({tc, tc9} !== {exp_tc, exp_tc9}) begin
          errors++;
          $display("FAIL xenb_tc cyc=%0d got tc=%b tc9=%b want %b %b", i, tc, tc9, exp_tc, exp_tc9);
        end
      end
      @(posedge clk); #1;
      e_item = sb_q.pop_front();
      checks++;
      if ({count, wrapped, count9, wrapped9} !== {e_item.c, e_item.w, e_item.c9, e_item.w9}) begin
        errors++;
        $display("FAIL xenb_state cyc=%0d got c=%0d w=%b c9=%0d w9=%b want c=%0d w=%b c9=%0d w9=%b",
                 i, count, wrapped, count9, wrapped9, e_item.c, e_item.w, e_item.c9, e_item.w9);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      drive((i == 0) || ($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ({tc, tc9} !== {exp_tc, exp_tc9}) begin
        errors++;
        $display("FAIL b2b_tc cyc=%0d got tc=%b tc9=%b want %b %b", i, tc, tc9, exp_tc, exp_tc9);
      end
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b2b_queue cyc=%0d got empty scoreboard want 1 entry", i);
      end else begin
        e_item = sb_q.pop_front();
        checks++;
        if ({count, wrapped, count9, wrapped9} !== {e_item.c, e_item.w, e_item.c9, e_item.w9}) begin
          errors++;
          $display("FAIL b2b_state cyc=%0d got c=%0d w=%b c9=%0d w9=%b want c=%0d w=%b c9=%0d w9=%b",
                   i, count, wrapped, count9, wrapped9, e_item.c, e_item.w, e_item.c9, e_item.w9);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    enb = 1'b0;
    m_c = 4'd0; m_w = 1'b0; m_c9 = 4'd0; m_w9 = 1'b0;
    tc_known = 1'b1;
    exp_tc = 1'b0;
    exp_tc9 = 1'b0;
    #1;
    test_reset();
    test_enable_gating();
    test_wrap();
    test_reset_mid();
    test_x_enb();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
